// File: rtl/byte_memory_if.sv
// Request/response bus for byte_memory: one access per cycle, no backpressure once ready.
interface byte_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BYTES = 2
);
  logic                             req;
  logic                             we;
  logic [ADDR_WIDTH-1:0]            addr;
  logic [DATA_WIDTH*WORD_BYTES-1:0] wdata;
  logic [WORD_BYTES-1:0]            be;
  logic                             ready;
  logic                             rvalid;
  logic [DATA_WIDTH*WORD_BYTES-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/byte_memory.sv
// Byte-addressed big-endian memory with multi-byte lanes, byte enables,
// a pipelined read path and an optional zero-fill sequence after reset.
module byte_memory #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int WORD_BYTES     = 2,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst,
  byte_memory_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - WORD_BYTES);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WORD_W-1:0]     read_word;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  clearing;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [WORD_W-1:0]       pipe_data [READ_LATENCY];

  // Reset wins over a simultaneous request, so rst gates acceptance.
  assign accept    = bus.req & ready & ~rst;
  assign wr_accept = accept & bus.we;
  assign rd_accept = accept & ~bus.we;
  assign clearing  = (state == ST_CLEAR) & ~rst;

  always_comb begin
    read_word = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      read_word[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH] = mem[bus.addr + ADDR_WIDTH'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      ready   <= !CLEAR_ON_RESET;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + STEP;
      if (clr_ptr == LAST_PTR) begin
        state <= ST_READY;
        ready <= 1'b1;
      end
    end
  end

  // Cells carry no reset; only the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    if (clearing) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        mem[clr_ptr + ADDR_WIDTH'(k)] <= '0;
      end
    end else if (wr_accept) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (bus.be[WORD_BYTES-1-k]) begin
          mem[bus.addr + ADDR_WIDTH'(k)] <= bus.wdata[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Data stages load only with a valid token, so the last stage holds rdata between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= read_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.rvalid = pipe_valid[READ_LATENCY-1];
  assign bus.rdata  = pipe_data[READ_LATENCY-1];
endmodule

// File: tb/tb_byte_memory.sv
// Scoreboard bench for byte_memory: three instances cover latency 1 with clear,
// latency 3 with clear, and latency 1 without clear.
module tb_byte_memory;
  typedef struct {
    logic [15:0] data;
    int          due;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic        rst_s   [3];
  logic        req_s   [3];
  logic        we_s    [3];
  logic [3:0]  addr_s  [3];
  logic [15:0] wdata_s [3];
  logic [1:0]  be_s    [3];
  logic        ready_s [3];
  logic        rvalid_s[3];
  logic [15:0] rdata_s [3];

  exp_t sb[3][$];

  byte_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2)) if_a ();
  byte_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2)) if_b ();
  byte_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2)) if_c ();

  assign if_a.req = req_s[0];  assign if_a.we = we_s[0];  assign if_a.addr = addr_s[0];
  assign if_a.wdata = wdata_s[0];  assign if_a.be = be_s[0];
  assign if_b.req = req_s[1];  assign if_b.we = we_s[1];  assign if_b.addr = addr_s[1];
  assign if_b.wdata = wdata_s[1];  assign if_b.be = be_s[1];
  assign if_c.req = req_s[2];  assign if_c.we = we_s[2];  assign if_c.addr = addr_s[2];
  assign if_c.wdata = wdata_s[2];  assign if_c.be = be_s[2];

  assign ready_s[0] = if_a.ready;  assign rvalid_s[0] = if_a.rvalid;  assign rdata_s[0] = if_a.rdata;
  assign ready_s[1] = if_b.ready;  assign rvalid_s[1] = if_b.rvalid;  assign rdata_s[1] = if_b.rdata;
  assign ready_s[2] = if_c.ready;  assign rvalid_s[2] = if_c.rvalid;  assign rdata_s[2] = if_c.rdata;

  byte_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1))
    dut_a (.clk(clk), .rst(rst_s[0]), .bus(if_a));
  byte_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1))
    dut_b (.clk(clk), .rst(rst_s[1]), .bus(if_b));
  byte_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_BYTES(2), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0))
    dut_c (.clk(clk), .rst(rst_s[2]), .bus(if_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int lat(input int which);
    return (which == 1) ? 3 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Each expected read result is due on one specific cycle; anything else is out of order or stray.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
        exp_t e;
        e = sb[i].pop_front();
        checkOutput({e.tag, "_rvalid"}, {31'd0, rvalid_s[i]}, 32'd1);
        checkOutput({e.tag, "_rdata"}, {16'd0, rdata_s[i]}, {16'd0, e.data});
      end else if (rvalid_s[i] === 1'b1) begin
        checkOutput("stray_rvalid", {31'd0, rvalid_s[i]}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input int which, input logic wr, input logic [3:0] a,
                               input logic [15:0] d, input logic [1:0] b,
                               input logic [15:0] exp_data, input string tag);
    exp_t e;
    req_s[which]   = 1'b1;
    we_s[which]    = wr;
    addr_s[which]  = a;
    wdata_s[which] = d;
    be_s[which]    = b;
    if (!wr) begin
      e.data = exp_data;
      e.due  = cyc + lat(which);
      e.tag  = tag;
      sb[which].push_back(e);
    end
    @(posedge clk);
    #1;
    req_s[which] = 1'b0;
    we_s[which]  = 1'b0;
  endtask

  task automatic doReset(input int which, input logic exp_ready);
    rst_s[which] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[which] = 1'b0;
    sb[which].delete();
    @(negedge clk);
    checkOutput("rst_rvalid", {31'd0, rvalid_s[which]}, 32'd0);
    checkOutput("rst_rdata", {16'd0, rdata_s[which]}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready_s[which]}, {31'd0, exp_ready});
  endtask

  task automatic waitReady(input int which, input int expected, input string tag);
    int n = 0;
    while (ready_s[which] !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput(tag, n, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b0; req_s[i] = 1'b0; we_s[i] = 1'b0;
      addr_s[i] = '0; wdata_s[i] = '0; be_s[i] = '0;
    end

    doReset(0, 1'b0);
    waitReady(0, 8, "a_clear_cycles");
    applyStimulus(0, 1'b0, 4'd5, 16'h0, 2'b00, 16'h0000, "a_rd5_cleared");
    applyStimulus(0, 1'b1, 4'd3, 16'hA55A, 2'b11, 16'h0, "");
    applyStimulus(0, 1'b0, 4'd3, 16'h0, 2'b00, 16'hA55A, "a_rd3");
    applyStimulus(0, 1'b0, 4'd4, 16'h0, 2'b00, 16'h5A00, "a_rd4_unaligned");
    applyStimulus(0, 1'b1, 4'd6, 16'h1234, 2'b01, 16'h0, "");
    applyStimulus(0, 1'b0, 4'd6, 16'h0, 2'b00, 16'h0034, "a_rd6_be");
    applyStimulus(0, 1'b1, 4'd15, 16'hBEEF, 2'b11, 16'h0, "");
    applyStimulus(0, 1'b0, 4'd15, 16'h0, 2'b00, 16'hBEEF, "a_rd15_wrap");
    applyStimulus(0, 1'b0, 4'd0, 16'h0, 2'b00, 16'hEF00, "a_rd0_wrap");
    idle(3);

    // A write issued while clearing must be dropped.
    doReset(0, 1'b0);
    applyStimulus(0, 1'b1, 4'd0, 16'hFFFF, 2'b11, 16'h0, "");
    @(negedge clk);
    waitReady(0, 7, "a_clear_after_req");
    applyStimulus(0, 1'b0, 4'd0, 16'h0, 2'b00, 16'h0000, "a_rd0_dropped_wr");
    idle(3);

    doReset(1, 1'b0);
    waitReady(1, 8, "b_clear_cycles");
    applyStimulus(1, 1'b1, 4'd0, 16'h0102, 2'b11, 16'h0, "");
    applyStimulus(1, 1'b1, 4'd2, 16'h0304, 2'b11, 16'h0, "");
    applyStimulus(1, 1'b1, 4'd4, 16'h0506, 2'b11, 16'h0, "");
    applyStimulus(1, 1'b0, 4'd0, 16'h0, 2'b00, 16'h0102, "b_rd0");
    applyStimulus(1, 1'b0, 4'd2, 16'h0, 2'b00, 16'h0304, "b_rd2");
    applyStimulus(1, 1'b0, 4'd4, 16'h0, 2'b00, 16'h0506, "b_rd4");
    idle(6);
    applyStimulus(1, 1'b0, 4'd0, 16'h0, 2'b00, 16'h0102, "b_rd0_pre_rst");
    applyStimulus(1, 1'b0, 4'd2, 16'h0, 2'b00, 16'h0304, "b_rd2_flushed");
    applyStimulus(1, 1'b0, 4'd4, 16'h0, 2'b00, 16'h0506, "b_rd4_flushed");
    doReset(1, 1'b0);
    waitReady(1, 8, "b_clear_after_flush");
    idle(3);

    doReset(2, 1'b1);
    waitReady(2, 0, "c_ready_now");
    applyStimulus(2, 1'b1, 4'd8, 16'hCAFE, 2'b11, 16'h0, "");
    applyStimulus(2, 1'b0, 4'd8, 16'h0, 2'b00, 16'hCAFE, "c_rd8");
    idle(2);
    doReset(2, 1'b1);
    applyStimulus(2, 1'b0, 4'd8, 16'h0, 2'b00, 16'hCAFE, "c_rd8_survives");
    idle(5);

    for (int i = 0; i < 3; i++) begin
      checkOutput("sb_drain", sb[i].size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/byte_memory.md
# byte_memory

Parametrised byte-addressed memory with multi-byte word access, per-byte write enables, a pipelined read path of configurable latency, and an optional zero-fill sequence after reset. It replaces the combinational two-byte read model in the processor's memory subsystem. Instruction fetch and data ports use it through a single request interface with one access per cycle and no backpressure once `ready` is high.

## Interface
- `DATA_WIDTH`, 8: bits per addressable byte cell.
- `ADDR_WIDTH`, 16: byte address width; depth = 2**ADDR_WIDTH cells.
- `WORD_BYTES`, 2: cells per access; power of two, 1..8.
- `READ_LATENCY`, 1: cycles from accepted read to `rvalid`; legal range 1..4.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill all cells after reset; 0 = contents untouched, ready immediately.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: access request, sampled at the rising edge.
- `we` in 1: 1 = write, 0 = read; valid with `req`.
- `addr` in ADDR_WIDTH: byte address of lane 0.
- `wdata` in DATA_WIDTH*WORD_BYTES: write data; lane 0 is the most significant DATA_WIDTH bits.
- `be` in WORD_BYTES: byte enables; `be[WORD_BYTES-1-k]` gates lane k, so the MSB gates lane 0.
- `ready` out 1: block accepts requests.
- `rvalid` out 1: `rdata` holds a read result this cycle.
- `rdata` out DATA_WIDTH*WORD_BYTES: read data, same lane order as `wdata`.

## Operation
- Lane k maps to cell `(addr + k) mod 2**ADDR_WIDTH`. Lane 0 (MSB) = `mem[addr]`, which is big-endian. Addresses wrap at the top of memory. Unaligned access is legal.
- A request is accepted when `req & ready` at a rising edge with `rst` low. When `ready` is low, requests are ignored and dropped, not queued.
- Write (`we`=1): at the accepting edge, each lane with its enable set updates its cell. Lanes with the enable clear are unchanged. No `rvalid` is produced.
- Read (`we`=0): the word is captured from memory contents after all earlier edges' writes. A write accepted at edge t is visible to a read accepted at edge t+1.
- Only one request occurs per cycle, so no same-edge read/write conflict exists.
- The read pipeline has READ_LATENCY stages. It accepts a new read every cycle, and results return in request order.
- FSM, two states:
  - CLEAR: `ready`=0. A pointer `clr_ptr` starts at 0 and steps by WORD_BYTES each cycle. Each cycle zeroes WORD_BYTES cells. After the cycle that clears the last word, the FSM moves to READY.
  - READY: `ready`=1. It stays here until `rst`.
- Reset entry: `rst` high moves the FSM to CLEAR (CLEAR_ON_RESET=1) or to READY (CLEAR_ON_RESET=0). It sets `clr_ptr`=0 and flushes all read pipeline stages.
- Reset outputs: `ready`=0 if CLEAR_ON_RESET else 1, `rvalid`=0, `rdata`=0.
- Memory cells are never reset directly. They are zeroed only by the CLEAR sequence.
- `rst` asserted mid-CLEAR restarts the clear from pointer 0.
- `rst` asserted with reads in flight discards them. `rvalid` is 0 in the cycle after the reset edge.
- `rst` together with `req`: reset wins. No memory write occurs and no read is queued.
- `rdata` holds its last read value while `rvalid`=0. It changes only when a result is delivered or on reset.

## Timing
- Read accepted at edge t: `rvalid`=1 and `rdata` valid during the cycle after edge t+READ_LATENCY-1. With READ_LATENCY=1, this is the cycle immediately after the request cycle.
- Back-to-back reads give back-to-back `rvalid`, one per cycle, in order.
- Write accepted at edge t takes effect at edge t.
- CLEAR duration: 2**ADDR_WIDTH / WORD_BYTES cycles after the last edge with `rst` high. `ready` rises at the edge that ends the final clear cycle.

## Test plan
Configuration for all scenarios unless stated: ADDR_WIDTH=4, WORD_BYTES=2, DATA_WIDTH=8, READ_LATENCY=1, CLEAR_ON_RESET=1.

- **Reset/clear:** pulse `rst` for 1 cycle.
  - `ready`=0 for exactly 8 cycles, then 1.
  - `rvalid`=0 and `rdata`=0 during reset.
  - A read of `addr`=5 then returns 0x0000.
- **Write/read and unaligned access:**
  - Write `addr`=3, `wdata`=0xA55A, `be`=2'b11. Read `addr`=3 next cycle: 0xA55A with `rvalid` 1 cycle later.
  - Read `addr`=4: 0x5A00.
- **Byte enables:** after clear, write `addr`=6, `wdata`=0x1234, `be`=2'b01. Read `addr`=6: 0x0034.
- **Wrap-around:** write `addr`=15, `wdata`=0xBEEF.
  - Read `addr`=15: 0xBEEF.
  - Read `addr`=0: 0xEF00.
- **Latency/pipeline (READ_LATENCY=3):**
  - Preload cells 0..5 with 0x01..0x06.
  - Issue back-to-back reads of `addr` 0, 2, 4. Expect `rvalid` high for 3 consecutive cycles starting 3 cycles after the first request, with data 0x0102, 0x0304, 0x0506.
  - Repeat, asserting `rst` 1 cycle after the last request. `rvalid` must be 0 from the cycle after the reset edge, and no stale data is delivered.
- **Requests during CLEAR:** issue a write of 0xFFFF to `addr`=0 while `ready`=0. After clear completes, a read of `addr`=0 returns 0x0000.
  - With CLEAR_ON_RESET=0, `ready`=1 in the cycle after reset, and previously written data survives the reset.
